display_scanner: RTL and testbench
==================================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter GUARD, default 2, cycles at slot start with all anodes off (anti-ghosting); SHALL be < REFRESH_DIV.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 value  input  32  eight hex nibbles; nibble k = value[4k+3:4k] drives digit k (digit 0 rightmost).
REQ-006 load  input  1  one-cycle request to capture value, dp_in, blank_lz into the pending buffer.
REQ-007 dp_in  input  8  decimal point request per digit, 1 = lit.
REQ-008 blank_lz  input  1  leading-zero blanking enable.
REQ-009 digit_en  input  8  live per-digit enable, 1 = digit may light; not buffered.
REQ-010 nibble  output  4  hex value of the active digit, feeds the 7-segment decoder.
REQ-011 an  output  8  anode enables, active-low, one-hot-low or all-high.
REQ-012 dp  output  1  decimal point cathode, active-low.
REQ-013 upd_ack  output  1  one-cycle pulse when a pending update becomes the displayed image.
REQ-014 frame_tick  output  1  one-cycle pulse when digit index wraps 7 -> 0.

Function
REQ-015 Prescaler counts 0..REFRESH_DIV-1 and wraps; at terminal count the digit index advances idx -> (idx+1) mod 8.
REQ-016 load SHALL be accepted every cycle; capture into pending registers and set pending_valid; load while pending_valid overwrites pending (last wins).
REQ-017 Pending transfers to the display image only at the cycle idx wraps 7 -> 0 (tear-free); same cycle: upd_ack=1, pending_valid cleared; frame_tick=1 on every wrap.
REQ-018 load in the same cycle as the wrap: captured into pending, NOT applied until the next wrap; upd_ack reflects only the older pending, if any.
REQ-019 Digit k is lead-blanked when image blank_lz=1, k>0, and image nibbles k..7 are all zero; digit 0 is never lead-blanked.
REQ-020 an[idx]=0 only when: prescaler count >= GUARD, digit_en[idx]=1, and digit idx not lead-blanked; all other an bits are 1 at all times.
REQ-021 nibble = image nibble idx; dp = ~image dp[idx] when an[idx]=0, else dp=1.
REQ-022 an, nibble, dp, upd_ack, frame_tick are registered; they reflect idx/counter state with exactly one cycle latency.
REQ-023 Full frame = 8*REFRESH_DIV cycles; no cycle has more than one anode low.
REQ-024 digit_en change takes effect one cycle later, mid-slot if necessary.

Reset
REQ-025 rst_n low asynchronously: prescaler=0, idx=0, image value=0, image dp=0, image blank_lz=0, pending_valid=0, an=8'hFF, nibble=0, dp=1, upd_ack=0, frame_tick=0.
REQ-026 Reset mid-frame discards pending and image; after release scanning restarts at digit 0, count 0, with first anode low at cycle GUARD+1.

Verification (REFRESH_DIV=4, GUARD=1)
REQ-027 Reset release, digit_en=FF, no load -> an sequence per slot: FF then FE x3, FF then FD x3 ... 7F; nibble=0 throughout; frame_tick every 32 cycles.
REQ-028 load value=32'h89ABCDEF, dp_in=8'h01 mid-frame -> image unchanged until next wrap; upd_ack pulse with frame_tick; next frame nibble = F,E,D,C,B,A,9,8; dp=0 only during digit 0 lit cycles.
REQ-029 load value=32'h0000_0A00, blank_lz=1 -> after wrap digits 3..7 an stay high, digits 0..2 light with nibbles 0,0,A; value=0 with blank_lz=1 -> only digit 0 lights showing 0.
REQ-030 Two loads (h11111111 then h22222222) before one wrap, plus third load on the wrap cycle (h33333333) -> one upd_ack, frame shows 2s; next wrap second upd_ack, frame shows 3s.
REQ-031 digit_en=8'hF0 -> digits 0..3 anodes never low, dp=1 in those slots; toggle digit_en[5] mid-slot 5 -> an[5] follows one cycle later.
REQ-032 rst_n pulsed low mid-slot 5 with pending_valid=1 -> an=FF immediately (asynchronous), no upd_ack after release, scan restarts at digit 0 showing 0.

Source files
------------

// File: rtl/display_scanner_if.sv
// rtl/display_scanner_if.sv - display scanner host/display bundle with master and slave views
interface display_scanner_if;
    logic [31:0] value;
    logic        load;
    logic [7:0]  dp_in;
    logic        blank_lz;
    logic [7:0]  digit_en;
    logic [3:0]  nibble;
    logic [7:0]  an;
    logic        dp;
    logic        upd_ack;
    logic        frame_tick;

    modport master (
        output value, load, dp_in, blank_lz, digit_en,
        input  nibble, an, dp, upd_ack, frame_tick
    );

    modport slave (
        input  value, load, dp_in, blank_lz, digit_en,
        output nibble, an, dp, upd_ack, frame_tick
    );
endinterface

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - 8-digit multiplexed 7-segment scanner with tear-free image updates
module display_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input logic               clk,
    input logic               rst_n,
    display_scanner_if.slave  bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;

    logic [31:0]   pend_val_q;
    logic [7:0]    pend_dp_q;
    logic          pend_blz_q;
    logic          pend_valid_q;

    logic [31:0]   img_val_q;
    logic [7:0]    img_dp_q;
    logic          img_blz_q;

    logic [7:0]    an_q, an_d;
    logic [3:0]    nibble_q, nibble_d;
    logic          dp_q, dp_d;
    logic          upd_ack_q, upd_ack_d;
    logic          frame_tick_q, frame_tick_d;

    logic          wrap_slot;
    logic          wrap_frame;
    logic          lit;
    logic [7:0]    zero_from;
    logic [7:0]    lz_blank;

    // Leading-zero mask: digit k blanks when it and every digit above it are zero
    always_comb begin
        zero_from    = '0;
        lz_blank     = '0;
        zero_from[7] = (img_val_q[31:28] == 4'h0);
        for (int k = 6; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (img_val_q[4*k +: 4] == 4'h0);
        end
        for (int k = 1; k < 8; k++) begin
            lz_blank[k] = img_blz_q && zero_from[k];
        end
    end

    // Prescaler/index next state and the next values of the registered outputs
    always_comb begin
        wrap_slot    = (cnt_q == CW'(REFRESH_DIV - 1));
        wrap_frame   = wrap_slot && (idx_q == 3'd7);
        cnt_d        = wrap_slot ? '0 : cnt_q + 1'b1;
        idx_d        = wrap_slot ? idx_q + 3'd1 : idx_q;
        lit          = (cnt_q >= CW'(GUARD)) && bus.digit_en[idx_q] && !lz_blank[idx_q];
        an_d         = lit ? ~(8'h01 << idx_q) : 8'hFF;
        nibble_d     = img_val_q[4*idx_q +: 4];
        dp_d         = lit ? ~img_dp_q[idx_q] : 1'b1;
        upd_ack_d    = wrap_frame && pend_valid_q;
        frame_tick_d = wrap_frame;
    end

    // Scan state, pending buffer, display image and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blz_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            img_val_q    <= '0;
            img_dp_q     <= '0;
            img_blz_q    <= 1'b0;
            an_q         <= 8'hFF;
            nibble_q     <= 4'h0;
            dp_q         <= 1'b1;
            upd_ack_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            nibble_q     <= nibble_d;
            dp_q         <= dp_d;
            upd_ack_q    <= upd_ack_d;
            frame_tick_q <= frame_tick_d;
            // A load on the wrap cycle refills pending after the old one moves to the image
            if (bus.load) begin
                pend_val_q   <= bus.value;
                pend_dp_q    <= bus.dp_in;
                pend_blz_q   <= bus.blank_lz;
                pend_valid_q <= 1'b1;
            end else if (wrap_frame) begin
                pend_valid_q <= 1'b0;
            end
            if (wrap_frame && pend_valid_q) begin
                img_val_q <= pend_val_q;
                img_dp_q  <= pend_dp_q;
                img_blz_q <= pend_blz_q;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.nibble     = nibble_q;
    assign bus.dp         = dp_q;
    assign bus.upd_ack    = upd_ack_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - directed self-checking bench for display_scanner
module tb_display_scanner;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    display_scanner_if bus ();

    display_scanner #(.REFRESH_DIV(4), .GUARD(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int          ld_cyc [4];
    logic [31:0] ld_v   [4];
    logic [7:0]  ld_d   [4];
    logic        ld_b   [4];
    int          n_ld = 0;
    int          en_cyc [4];
    logic [7:0]  en_v   [4];
    int          n_en = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_load(input int c, input logic [31:0] v, input logic [7:0] d, input logic b);
        ld_cyc[n_ld] = c;
        ld_v[n_ld]   = v;
        ld_d[n_ld]   = d;
        ld_b[n_ld]   = b;
        n_ld++;
    endtask

    task automatic add_en(input int c, input logic [7:0] v);
        en_cyc[n_en] = c;
        en_v[n_en]   = v;
        n_en++;
    endtask

    // One full 32-cycle frame starting at the first edge of digit 0, count 0.
    // nibs: expected displayed image, vis: digits not lead-blanked, dpm: image dp bits.
    task automatic run_frame(input int f, input logic [31:0] nibs, input logic [7:0] vis,
                             input logic [7:0] dpm, input logic exp_ack);
        logic [7:0] cur_en;
        logic [7:0] exp_an;
        logic       lit;
        int         slot;
        int         ph;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < n_ld; j++) begin
                if (ld_cyc[j] == i) begin
                    bus.value    = ld_v[j];
                    bus.dp_in    = ld_d[j];
                    bus.blank_lz = ld_b[j];
                    bus.load     = 1'b1;
                end
            end
            for (int j = 0; j < n_en; j++) begin
                if (en_cyc[j] == i) bus.digit_en = en_v[j];
            end
            cur_en = bus.digit_en;
            @(posedge clk);
            #1;
            bus.load = 1'b0;
            slot   = i / 4;
            ph     = i % 4;
            lit    = (ph >= 1) && vis[slot] && cur_en[slot];
            exp_an = lit ? ~(8'h01 << slot) : 8'hFF;
            check($sformatf("an f%0d c%0d", f, i), 32'(bus.an), 32'(exp_an));
            check($sformatf("nibble f%0d c%0d", f, i), 32'(bus.nibble), 32'(nibs[4*slot +: 4]));
            check($sformatf("dp f%0d c%0d", f, i), 32'(bus.dp), 32'((lit && dpm[slot]) ? 1'b0 : 1'b1));
            check($sformatf("frame_tick f%0d c%0d", f, i), 32'(bus.frame_tick), 32'(i == 31));
            check($sformatf("upd_ack f%0d c%0d", f, i), 32'(bus.upd_ack), 32'((i == 31) && exp_ack));
        end
        n_ld = 0;
        n_en = 0;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.value    = '0;
        bus.load     = 1'b0;
        bus.dp_in    = '0;
        bus.blank_lz = 1'b0;
        bus.digit_en = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst an", 32'(bus.an), 32'h0000_00FF);
        check("rst nibble", 32'(bus.nibble), 32'h0);
        check("rst dp", 32'(bus.dp), 32'h1);
        check("rst upd_ack", 32'(bus.upd_ack), 32'h0);
        check("rst frame_tick", 32'(bus.frame_tick), 32'h0);
        rst_n = 1'b1;

        // blank scan, load lands mid-frame and is held back until the wrap
        add_load(10, 32'h89AB_CDEF, 8'h01, 1'b0);
        run_frame(0, 32'h0000_0000, 8'hFF, 8'h00, 1'b1);
        add_load(5, 32'h0000_0A00, 8'h00, 1'b1);
        run_frame(1, 32'h89AB_CDEF, 8'hFF, 8'h01, 1'b1);
        add_load(3, 32'h0000_0000, 8'h00, 1'b1);
        run_frame(2, 32'h0000_0A00, 8'h07, 8'h00, 1'b1);
        // last-wins overwrite plus a load on the wrap cycle itself
        add_load(4,  32'h1111_1111, 8'h00, 1'b0);
        add_load(8,  32'h2222_2222, 8'h00, 1'b0);
        add_load(31, 32'h3333_3333, 8'h00, 1'b0);
        run_frame(3, 32'h0000_0000, 8'h01, 8'h00, 1'b1);
        run_frame(4, 32'h2222_2222, 8'hFF, 8'h00, 1'b1);
        add_load(2, 32'h7654_3210, 8'hFF, 1'b0);
        run_frame(5, 32'h3333_3333, 8'hFF, 8'h00, 1'b1);
        // live digit enables, with digit 5 dropped for one cycle mid-slot
        add_en(0, 8'hF0);
        add_en(22, 8'hD0);
        add_en(23, 8'hF0);
        run_frame(6, 32'h7654_3210, 8'hFF, 8'hFF, 1'b0);

        // reset in slot 5 with an update pending
        bus.digit_en = 8'hFF;
        for (int i = 0; i < 22; i++) begin
            if (i == 2) begin
                bus.value = 32'hFFFF_FFFF;
                bus.dp_in = 8'hFF;
                bus.load  = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.load = 1'b0;
        end
        check("pre-reset an slot5", 32'(bus.an), 32'h0000_00DF);
        check("pre-reset nibble slot5", 32'(bus.nibble), 32'h5);
        rst_n = 1'b0;
        #1;
        check("async rst an", 32'(bus.an), 32'h0000_00FF);
        check("async rst nibble", 32'(bus.nibble), 32'h0);
        check("async rst dp", 32'(bus.dp), 32'h1);
        check("async rst upd_ack", 32'(bus.upd_ack), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(8, 32'h0000_0000, 8'hFF, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
